context_template_buffer: RTL
============================

CONTEXT_TEMPLATE_BUFFER -- requirements
Module: context_template_buffer

Interface
REQ-001 Parameter pixel_length, default 8, bit width of one sample.
REQ-002 Parameter image_width, default 512, samples per line; legal range is 2 to 2^col_length.
REQ-003 Parameter image_height, default 512, lines per frame; legal range is 1 to 2^row_length.
REQ-004 Parameter col_length, default 9, column counter width.
REQ-005 Parameter row_length, default 9, row counter width.
REQ-006 The ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel_in is valid this cycle.
- in_ready  out  1  block accepts pixel_in this cycle.
- pixel_in  in  pixel_length  raster-order sample x.
- out_valid  out  1  output bundle is valid.
- out_ready  in  1  downstream (gradient quantization stage) accepts the bundle.
- x  out  pixel_length  current sample.
- a, b, c, d  out  pixel_length each  causal neighbours: a left, b above, c above-left, d above-right.
- col  out  col_length  column of x.
- row  out  row_length  row of x.
- sol  out  1  x is column 0.
- eol  out  1  x is column image_width-1.
- eof  out  1  x is the last sample of the frame.

Function
REQ-007 The block SHALL accept a transfer when in_valid and in_ready are both 1 on a rising clk edge.
REQ-008 in_ready SHALL equal (!out_valid || out_ready), giving a single registered stage with no combinational path from in_valid to out_valid.
REQ-009 The output bundle SHALL be registered on acceptance, giving a latency of 1 cycle from accepted input to out_valid=1.
REQ-010 out_valid SHALL be set on acceptance, cleared when out_ready=1 with no new acceptance, and held while out_ready=0.
REQ-011 Output registers SHALL hold their values while out_valid=1 and out_ready=0.
REQ-012 Line storage SHALL be one line of image_width entries holding the previous row; the entry for column k SHALL be read before it is overwritten by the current sample at column k.
REQ-013 Registered c-state SHALL hold the previous row's sample at column k-1; a register SHALL hold the current row's sample at column k-1.
REQ-014 Interior sample (row>0, 0<col<image_width-1): a=X[r][k-1], b=X[r-1][k], c=X[r-1][k-1], d=X[r-1][k+1].
REQ-015 Row 0: b=c=d=0; a=X[0][k-1] for k>0 and a=0 at k=0.
REQ-016 Column 0 with row>0: a=b=X[r-1][0]; c=X[r-2][0] for row>=2 and c=0 for row 1.
REQ-017 Last column with row>0: d=b.
REQ-018 When image_width=2, the REQ-016 and REQ-017 rules SHALL both apply where relevant.
REQ-019 col SHALL increment on each acceptance and wrap from image_width-1 to 0; on that wrap row SHALL increment.
REQ-020 At the frame's last sample, row and col SHALL return to 0, and the next frame SHALL be treated as row 0 without clearing memory (row==0 gating).
REQ-021 sol, eol and eof SHALL be registered with the bundle and decoded from the counters of the accepted sample.
REQ-022 Arithmetic SHALL be unsigned, with no sample value modification.

Reset
REQ-023 On reset_n=0, asynchronously: out_valid=0; x, a, b, c, d, col, row = 0; sol=eol=eof=0; counters and the a/c registers = 0.
REQ-024 in_ready SHALL be 1 while out_valid=0, including during and after reset.
REQ-025 Line memory contents need not be reset.
REQ-026 Reset asserted mid-frame SHALL discard the frame; the first accepted sample after reset_n rises SHALL be treated as row 0, col 0.

Verification (image_width=4, image_height=3, pixel_length=8)
REQ-027 Scenario, row 0: samples 10,20,30,40 with out_ready=1 -> bundles (x,a,b,c,d) = (10,0,0,0,0), (20,10,0,0,0), (30,20,0,0,0), (40,30,0,0,0); eol=1 on the 4th bundle; each bundle 1 cycle after its input.
REQ-028 Scenario, row 1: samples 11,21,31,41 -> bundles (11,10,10,0,20), (21,11,20,10,30), (31,21,30,20,40), (41,31,40,30,40).
REQ-029 Scenario, row 2: samples 12,22,32,42 -> first bundle (12,11,11,10,21); last bundle (42,32,41,31,41) with eof=1; next accepted sample yields row=0, b=c=d=0.
REQ-030 Scenario, backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle stable, no sample lost or duplicated; resuming out_ready=1 continues the sequence exactly.
REQ-031 Scenario, bubbles: in_valid toggled 1/0 each cycle -> same bundle values as the continuous case; out_valid deasserts in gaps when out_ready=1.
REQ-032 Scenario, reset during row 1 col 2: then samples 5,6 -> (5,0,0,0,0), (6,5,0,0,0); out_valid=0 and outputs 0 while reset_n=0.

Source files
------------

// File: rtl/context_template_buffer.sv
`default_nettype none
// ============================================================================
// Module   : context_template_buffer
// Purpose  : Raster-order causal context (x, a, b, c, d) builder with one
//            registered valid/ready stage and a single line of storage.
// Revision : 1.0 - initial release
// ============================================================================
module context_template_buffer #(
   parameter int pixel_length = 8,
   parameter int image_width  = 512,
   parameter int image_height = 512,
   parameter int col_length   = 9,
   parameter int row_length   = 9
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [pixel_length-1:0] pixel_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [pixel_length-1:0] x,
   output logic [pixel_length-1:0] a,
   output logic [pixel_length-1:0] b,
   output logic [pixel_length-1:0] c,
   output logic [pixel_length-1:0] d,
   output logic [col_length-1:0]   col,
   output logic [row_length-1:0]   row,
   output logic                    sol,
   output logic                    eol,
   output logic                    eof
);

   localparam logic [col_length-1:0] c_last_col = col_length'(image_width - 1);
   localparam logic [row_length-1:0] c_last_row = row_length'(image_height - 1);
   localparam logic [col_length-1:0] c_col_one  = col_length'(1);
   localparam logic [row_length-1:0] c_row_one  = row_length'(1);

   logic [pixel_length-1:0] line_q [0:image_width-1];

   logic                    out_valid_q, out_valid_d;
   logic [pixel_length-1:0] x_q, x_d, a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic [col_length-1:0]   col_q, col_d, cnt_col_q, cnt_col_d;
   logic [row_length-1:0]   row_q, row_d, cnt_row_q, cnt_row_d;
   logic                    sol_q, sol_d, eol_q, eol_d, eof_q, eof_d;
   // left_q: current row at k-1; up_left_q: previous row at k-1;
   // up2_first_q: column 0 two rows back, needed for c at the start of a line.
   logic [pixel_length-1:0] left_q, left_d, up_left_q, up_left_d;
   logic [pixel_length-1:0] up2_first_q, up2_first_d;

   logic                    accept;
   logic                    first_row, first_col, last_col, last_row;
   logic [col_length-1:0]   d_idx;
   logic [pixel_length-1:0] b_raw, d_raw;
   logic [pixel_length-1:0] nxt_a, nxt_b, nxt_c, nxt_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      first_row = (cnt_row_q == '0);
      first_col = (cnt_col_q == '0);
      last_col  = (cnt_col_q == c_last_col);
      last_row  = (cnt_row_q == c_last_row);
      d_idx     = last_col ? cnt_col_q : cnt_col_q + c_col_one;
      // Both reads happen before the write of this sample lands at cnt_col_q.
      b_raw     = line_q[cnt_col_q];
      d_raw     = line_q[d_idx];

      // Row 0 gating hides stale line contents from the previous frame.
      nxt_b = first_row ? '0 : b_raw;
      nxt_a = first_col ? nxt_b : left_q;
      if (first_row) begin
         nxt_c = '0;
      end else if (first_col) begin
         nxt_c = (cnt_row_q == c_row_one) ? '0 : up2_first_q;
      end else begin
         nxt_c = up_left_q;
      end
      if (first_row) begin
         nxt_d = '0;
      end else if (last_col) begin
         nxt_d = b_raw;
      end else begin
         nxt_d = d_raw;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      x_d         = x_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      d_d         = d_q;
      col_d       = col_q;
      row_d       = row_q;
      sol_d       = sol_q;
      eol_d       = eol_q;
      eof_d       = eof_q;
      cnt_col_d   = cnt_col_q;
      cnt_row_d   = cnt_row_q;
      left_d      = left_q;
      up_left_d   = up_left_q;
      up2_first_d = up2_first_q;

      if (accept) begin
         out_valid_d = 1'b1;
         x_d         = pixel_in;
         a_d         = nxt_a;
         b_d         = nxt_b;
         c_d         = nxt_c;
         d_d         = nxt_d;
         col_d       = cnt_col_q;
         row_d       = cnt_row_q;
         sol_d       = first_col;
         eol_d       = last_col;
         eof_d       = last_col && last_row;
         left_d      = pixel_in;
         up_left_d   = b_raw;
         if (first_col) begin
            up2_first_d = b_raw;
         end
         if (last_col) begin
            cnt_col_d = '0;
            cnt_row_d = last_row ? '0 : cnt_row_q + c_row_one;
         end else begin
            cnt_col_d = cnt_col_q + c_col_one;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         x_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         col_q       <= '0;
         row_q       <= '0;
         sol_q       <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
         cnt_col_q   <= '0;
         cnt_row_q   <= '0;
         left_q      <= '0;
         up_left_q   <= '0;
         up2_first_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         x_q         <= x_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         d_q         <= d_d;
         col_q       <= col_d;
         row_q       <= row_d;
         sol_q       <= sol_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
         cnt_col_q   <= cnt_col_d;
         cnt_row_q   <= cnt_row_d;
         left_q      <= left_d;
         up_left_q   <= up_left_d;
         up2_first_q <= up2_first_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         line_q[cnt_col_q] <= pixel_in;
      end
   end

   assign out_valid = out_valid_q;
   assign x         = x_q;
   assign a         = a_q;
   assign b         = b_q;
   assign c         = c_q;
   assign d         = d_q;
   assign col       = col_q;
   assign row       = row_q;
   assign sol       = sol_q;
   assign eol       = eol_q;
   assign eof       = eof_q;

endmodule
`default_nettype wire
